// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load results into the single regfile write port.
// Optional ALU starvation guard is enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,

    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,

    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_MEM
    } grant_t;

    logic        alu_full;
    logic [4:0]  alu_rd_q;
    logic [31:0] alu_data_q;
    logic        mem_full;
    logic [4:0]  mem_rd_q;
    logic [31:0] mem_data_q;

    grant_t      grant;
    logic        alu_force;
    logic        alu_take;
    logic        mem_take;
    logic [4:0]  drain_rd;
    logic [31:0] drain_data;
    logic        write_en;

`ifdef WB_STARVE_GUARD_EN
    localparam logic [1:0] STARVE_LIMIT = 2'(STARVE_MAX);

    // Counts consecutive cycles the ALU entry sat full while the load entry won.
    logic [1:0] starve_cnt;

    assign alu_force = (starve_cnt == STARVE_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 2'd0;
        end else if (!alu_full || grant == GNT_ALU) begin
            starve_cnt <= 2'd0;
        end else if (grant == GNT_MEM) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end
`else
    // Strict load priority; the limit parameter only matters with the guard built in.
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
    assign alu_force = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant = GNT_NONE;
        if (mem_full && !(alu_full && alu_force)) begin
            grant = GNT_MEM;
        end else if (alu_full) begin
            grant = GNT_ALU;
        end
    end

    // A buffer can refill on the same edge it drains, giving one result per cycle per source.
    assign alu_ready = reset_n & (~alu_full | (grant == GNT_ALU));
    assign mem_ready = reset_n & (~mem_full | (grant == GNT_MEM));
    assign alu_take  = alu_valid & alu_ready;
    assign mem_take  = mem_valid & mem_ready;

    always_comb begin
        drain_rd   = alu_rd_q;
        drain_data = alu_data_q;
        if (grant == GNT_MEM) begin
            drain_rd   = mem_rd_q;
            drain_data = mem_data_q;
        end
    end

    // Entries targeting x0 are consumed but never reach the regfile.
    assign write_en = (grant != GNT_NONE) && (drain_rd != 5'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_full <= 1'b0;
            mem_full <= 1'b0;
        end else begin
            if (alu_take) begin
                alu_full <= 1'b1;
            end else if (grant == GNT_ALU) begin
                alu_full <= 1'b0;
            end
            if (mem_take) begin
                mem_full <= 1'b1;
            end else if (grant == GNT_MEM) begin
                mem_full <= 1'b0;
            end
        end
    end

    // NOTE: payload registers carry no reset; the full flags alone decide whether they mean anything.
    always_ff @(posedge clock) begin
        if (alu_take) begin
            alu_rd_q   <= alu_rd;
            alu_data_q <= alu_data;
        end
        if (mem_take) begin
            mem_rd_q   <= mem_rd;
            mem_data_q <= mem_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we3 <= 1'b0;
            wa3 <= 5'd0;
            wd3 <= 32'd0;
        end else begin
            we3 <= write_en;
            if (write_en) begin
                wa3 <= drain_rd;
                wd3 <= drain_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, corner sequences and a randomized
// run against a transaction-level reference model. Honours WB_STARVE_GUARD_EN.
module tb_wb_arbiter;

    localparam int STARVE_MAX = 3;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;

    int n_vec = 0;
    int n_bad = 0;

    wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mdat);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    endtask

    // Called at a negedge: let one rising edge pass, then sample just after it.
    task automatic edge_then_sample();
        @(posedge clock);
        #1;
    endtask

    task automatic to_negedge();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            edge_then_sample();
            to_negedge();
        end
    endtask

    typedef struct {
        bit          av;
        logic [4:0]  ard;
        logic [31:0] adat;
        bit          mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        bit          e_ar;
        bit          e_mr;
        bit          e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    typedef struct {
        bit          full;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    vec_t tbl[13];

    initial begin
        // Directed vectors from a fresh reset: readies are pre-edge, write port is post-edge.
        tbl[0]  = '{1, 5'd5,  32'h12345678, 0, 5'd0,  32'h0,        1, 1, 0, 5'd0,  32'h0};
        tbl[1]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1, 1, 5'd5,  32'h12345678};
        tbl[2]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1, 0, 5'd5,  32'h12345678};
        tbl[3]  = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h87654321, 1, 1, 0, 5'd5,  32'h12345678};
        tbl[4]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1, 0, 5'd5,  32'h12345678};
        tbl[5]  = '{1, 5'd10, 32'h0A0A000A, 1, 5'd11, 32'h0B0B000B, 1, 1, 0, 5'd5,  32'h12345678};
        tbl[6]  = '{1, 5'd12, 32'h0C0C000C, 1, 5'd13, 32'h0D0D000D, 0, 1, 1, 5'd11, 32'h0B0B000B};
        tbl[7]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 1, 5'd13, 32'h0D0D000D};
        tbl[8]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1, 1, 5'd10, 32'h0A0A000A};
        tbl[9]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1, 0, 5'd10, 32'h0A0A000A};
        tbl[10] = '{1, 5'd0,  32'h00000099, 1, 5'd7,  32'h00000070, 1, 1, 0, 5'd10, 32'h0A0A000A};
        tbl[11] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 1, 5'd7,  32'h00000070};
        tbl[12] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1, 0, 5'd7,  32'h00000070};

        // ---- power-on reset ----
        #2;
        check("reset_we3", 32'(we3), 0);
        check("reset_wa3", 32'(wa3), 0);
        check("reset_wd3", wd3, 0);
        check("reset_alu_ready", 32'(alu_ready), 0);
        check("reset_mem_ready", 32'(mem_ready), 0);
        #10 reset_n = 1'b1;                       // released between edges
        to_negedge();
        check("post_reset_alu_ready", 32'(alu_ready), 1);
        check("post_reset_mem_ready", 32'(mem_ready), 1);

        // ---- directed table ----
        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].mv, tbl[i].mrd, tbl[i].mdat);
            #1;
            check($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
            check($sformatf("tbl%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
            edge_then_sample();
            check($sformatf("tbl%0d_we3", i), 32'(we3), 32'(tbl[i].e_we));
            check($sformatf("tbl%0d_wa3", i), 32'(wa3), 32'(tbl[i].e_wa));
            check($sformatf("tbl%0d_wd3", i), wd3, tbl[i].e_wd);
            to_negedge();
        end

        // ---- contention: both sources offer continuously ----
        for (int s = 0; s < 13; s++) begin
            bit alu_turn;
            alu_turn = GUARD && (s % 4 == 0) && (s > 0);
            drive(1, 5'd30, 32'hA1A10030, 1, 5'd31, 32'hB2B20031);
            #1;
            check($sformatf("cont%0d_alu_ready", s), 32'(alu_ready), 32'((s == 0) || alu_turn));
            check($sformatf("cont%0d_mem_ready", s), 32'(mem_ready), 32'(!alu_turn));
            edge_then_sample();
            if (s > 0) begin
                check($sformatf("cont%0d_we3", s), 32'(we3), 1);
                check($sformatf("cont%0d_wa3", s), 32'(wa3), alu_turn ? 32'd30 : 32'd31);
                check($sformatf("cont%0d_wd3", s), wd3, alu_turn ? 32'hA1A10030 : 32'hB2B20031);
            end
            to_negedge();
        end
        idle(3);

        // ---- throughput: ALU alone, one result per cycle ----
        for (int j = 0; j <= 32; j++) begin
            if (j < 32) drive(1, 5'(j), 32'(j), 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0);
            #1;
            if (j < 32) check($sformatf("thr%0d_alu_ready", j), 32'(alu_ready), 1);
            edge_then_sample();
            if (j >= 1) check($sformatf("thr%0d_we3", j), 32'(we3), 32'(j != 1));
            if (j >= 2) begin
                check($sformatf("thr%0d_wa3", j), 32'(wa3), 32'(j - 1));
                check($sformatf("thr%0d_wd3", j), wd3, 32'(j - 1));
            end
            to_negedge();
        end
        idle(2);

        // ---- reset mid-operation with both buffers full ----
        drive(1, 5'd3, 32'h33333333, 1, 5'd4, 32'h44444444);
        edge_then_sample();
        to_negedge();
        drive(0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_we3", 32'(we3), 0);
        check("midrst_wa3", 32'(wa3), 0);
        check("midrst_wd3", wd3, 0);
        check("midrst_alu_ready", 32'(alu_ready), 0);
        check("midrst_mem_ready", 32'(mem_ready), 0);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("midrst%0d_alu_ready", k), 32'(alu_ready), 1);
            check($sformatf("midrst%0d_mem_ready", k), 32'(mem_ready), 1);
            edge_then_sample();
            check($sformatf("midrst%0d_we3", k), 32'(we3), 0);
            to_negedge();
        end

        // ---- randomized run against a transaction-level model ----
        begin
            ent_t        m_alu, m_mem;
            int          losses;
            logic [4:0]  m_wa;
            logic [31:0] m_wd;
            bit          m_we, alu_wins, mem_wins, e_ar, e_mr;
            m_alu = '{0, 0, 0};
            m_mem = '{0, 0, 0};
            losses = 0;
            m_wa = 0;                              // left at zero by the reset above
            m_wd = 0;
            for (int c = 0; c < 400; c++) begin
                bit av, mv;
                logic [4:0] ard, mrd;
                logic [31:0] adat, mdat;
                av = ($urandom_range(0, 99) < 70);
                mv = ($urandom_range(0, 99) < 60);
                ard = 5'($urandom); adat = $urandom;
                mrd = 5'($urandom); mdat = $urandom;
                drive(av, ard, adat, mv, mrd, mdat);

                if (m_alu.full && m_mem.full) begin
                    alu_wins = GUARD && (losses >= STARVE_MAX);
                    mem_wins = !alu_wins;
                end else begin
                    alu_wins = m_alu.full;
                    mem_wins = m_mem.full;
                end
                e_ar = !m_alu.full || alu_wins;
                e_mr = !m_mem.full || mem_wins;
                #1;
                check($sformatf("rnd%0d_alu_ready", c), 32'(alu_ready), 32'(e_ar));
                check($sformatf("rnd%0d_mem_ready", c), 32'(mem_ready), 32'(e_mr));

                m_we = 0;
                if (mem_wins && m_mem.rd != 0) begin
                    m_we = 1; m_wa = m_mem.rd; m_wd = m_mem.data;
                end
                if (alu_wins && m_alu.rd != 0) begin
                    m_we = 1; m_wa = m_alu.rd; m_wd = m_alu.data;
                end
                losses = (m_alu.full && mem_wins) ? losses + 1 : 0;
                if (av && e_ar)    m_alu = '{1, ard, adat};
                else if (alu_wins) m_alu.full = 0;
                if (mv && e_mr)    m_mem = '{1, mrd, mdat};
                else if (mem_wins) m_mem.full = 0;

                edge_then_sample();
                check($sformatf("rnd%0d_we3", c), 32'(we3), 32'(m_we));
                check($sformatf("rnd%0d_wa3", c), 32'(wa3), 32'(m_wa));
                check($sformatf("rnd%0d_wd3", c), wd3, m_wd);
                to_negedge();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
